// File: rtl/to_udp_adapter_pkg.sv
// to_udp_adapter_pkg: widths, descriptor and flit layouts shared by the UDP TX adapter
package to_udp_adapter_pkg;

    localparam int XY_WIDTH         = 8;
    localparam int NOC_FBITS_WIDTH  = 4;
    localparam int MSG_LENGTH_WIDTH = 22;
    localparam int MSG_TYPE_WIDTH   = 8;
    localparam int DATA_FLITS_W     = 17;

    localparam logic [MSG_TYPE_WIDTH-1:0] UDP_TX_SEGMENT = 8'd20;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

    // Header fields occupy the top bits of the flit; the rest of the flit is zero.
    typedef struct packed {
        logic [XY_WIDTH-1:0]         dst_x;
        logic [XY_WIDTH-1:0]         dst_y;
        logic [NOC_FBITS_WIDTH-1:0]  dst_fbits;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [MSG_TYPE_WIDTH-1:0]   msg_type;
        logic [XY_WIDTH-1:0]         src_x;
        logic [XY_WIDTH-1:0]         src_y;
        logic [NOC_FBITS_WIDTH-1:0]  src_fbits;
    } udp_noc_hdr_flit;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_tx_metadata_flit;

    typedef enum logic [1:0] {FLIT_NONE, FLIT_HDR, FLIT_META, FLIT_DATA} flit_sel_e;

    // ceil(len / 2^bytes_w) using a 17-bit sum so a 16-bit length never overflows
    function automatic logic [DATA_FLITS_W-1:0] calc_data_flits(input logic [15:0] len, input int unsigned bytes_w);
        logic [DATA_FLITS_W-1:0] sum;
        sum = {1'b0, len} + ((DATA_FLITS_W'(1) << bytes_w) - DATA_FLITS_W'(1));
        return sum >> bytes_w;
    endfunction

endpackage

// File: rtl/to_udp_adapter_datap.sv
// to_udp_datap: descriptor register, flit counter, flit muxing; length check under TO_UDP_LEN_CHECK_EN
module to_udp_datap
    import to_udp_adapter_pkg::*;
#(
    parameter int                         NOC_DATA_W = 512,
    parameter logic [XY_WIDTH-1:0]        SRC_X      = '0,
    parameter logic [XY_WIDTH-1:0]        SRC_Y      = '0,
    parameter logic [XY_WIDTH-1:0]        DST_X      = '0,
    parameter logic [XY_WIDTH-1:0]        DST_Y      = '0,
    parameter logic [NOC_FBITS_WIDTH-1:0] DST_FBITS  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_info_i,
    input  logic                  incr_cnt_i,
    input  flit_sel_e             flit_sel_i,
    input  udp_info               info_i,
    input  logic [NOC_DATA_W-1:0] src_data_i,
    input  logic                  src_data_last_i,
    output logic [NOC_DATA_W-1:0] noc_data_o,
    output logic                  datap_ctrl_last_data,
    output logic                  datap_ctrl_no_data,
    output logic                  len_err_o
);

    localparam int NOC_BYTES   = NOC_DATA_W / 8;
    localparam int NOC_BYTES_W = $clog2(NOC_BYTES);

    udp_info                 info_q, info_d;
    logic [DATA_FLITS_W-1:0] data_flits_q, data_flits_d;
    logic [DATA_FLITS_W-1:0] cnt_q, cnt_d;
    udp_noc_hdr_flit         hdr;
    udp_tx_metadata_flit     meta;
    logic [NOC_DATA_W-1:0]   hdr_word, meta_word;

    // latch the descriptor and its flit count on accept; count accepted payload flits
    always_comb begin
        info_d       = store_info_i ? info_i : info_q;
        data_flits_d = store_info_i ? calc_data_flits(info_i.data_length, NOC_BYTES_W) : data_flits_q;
        cnt_d        = store_info_i ? '0 : incr_cnt_i ? cnt_q + DATA_FLITS_W'(1) : cnt_q;
    end

    // descriptor, flit count and payload counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            info_q       <= '0;
            data_flits_q <= '0;
            cnt_q        <= '0;
        end else begin
            info_q       <= info_d;
            data_flits_q <= data_flits_d;
            cnt_q        <= cnt_d;
        end
    end

    // build header and metadata flits, fields packed into the top bits
    always_comb begin
        hdr                       = '0;
        hdr.dst_x                 = DST_X;
        hdr.dst_y                 = DST_Y;
        hdr.dst_fbits             = DST_FBITS;
        hdr.msg_len               = MSG_LENGTH_WIDTH'(data_flits_q) + MSG_LENGTH_WIDTH'(1);
        hdr.msg_type              = UDP_TX_SEGMENT;
        hdr.src_x                 = SRC_X;
        hdr.src_y                 = SRC_Y;
        meta                      = '0;
        meta.src_ip               = info_q.src_ip;
        meta.dst_ip               = info_q.dst_ip;
        meta.src_port             = info_q.src_port;
        meta.dst_port             = info_q.dst_port;
        meta.data_length          = info_q.data_length;
        hdr_word                  = '0;
        hdr_word[NOC_DATA_W-1 -: $bits(udp_noc_hdr_flit)] = hdr;
        meta_word                 = '0;
        meta_word[NOC_DATA_W-1 -: $bits(udp_tx_metadata_flit)] = meta;
    end

    assign noc_data_o = (flit_sel_i == FLIT_HDR)  ? hdr_word  :
                        (flit_sel_i == FLIT_META) ? meta_word :
                        (flit_sel_i == FLIT_DATA) ? src_data_i : '0;

    assign datap_ctrl_last_data = cnt_q == data_flits_q - DATA_FLITS_W'(1);
    assign datap_ctrl_no_data   = data_flits_q == '0;

`ifdef TO_UDP_LEN_CHECK_EN
    logic len_err_q, len_err_d;

    assign len_err_d = len_err_q | (incr_cnt_i & (src_data_last_i != datap_ctrl_last_data));
    assign len_err_o = len_err_q;

    // sticky flag: source last marker disagreed with counter framing
    always_ff @(posedge clk) begin
        len_err_q <= rst ? 1'b0 : len_err_d;
    end
`else
    logic unused_last;

    assign unused_last = src_data_last_i;
    assign len_err_o   = 1'b0;
`endif

endmodule

// File: rtl/to_udp_adapter.sv
// to_udp_adapter: app-to-UDP-TX message builder (hdr, meta, payload flits); optional TO_UDP_LEN_CHECK_EN
module to_udp_adapter
    import to_udp_adapter_pkg::*;
#(
    parameter int                         NOC_DATA_W = 512,
    parameter logic [XY_WIDTH-1:0]        SRC_X      = '0,
    parameter logic [XY_WIDTH-1:0]        SRC_Y      = '0,
    parameter logic [XY_WIDTH-1:0]        DST_X      = '0,
    parameter logic [XY_WIDTH-1:0]        DST_Y      = '0,
    parameter logic [NOC_FBITS_WIDTH-1:0] DST_FBITS  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_to_udp_meta_val,
    input  udp_info               src_to_udp_meta_info,
    output logic                  to_udp_src_meta_rdy,
    input  logic                  src_to_udp_data_val,
    input  logic [NOC_DATA_W-1:0] src_to_udp_data,
    input  logic                  src_to_udp_data_last,
    output logic                  to_udp_src_data_rdy,
    output logic                  noc_to_udp_val,
    output logic [NOC_DATA_W-1:0] noc_to_udp_data,
    input  logic                  udp_to_noc_rdy,
    output logic                  len_err
);

    localparam logic [1:0] READY = 2'd0;
    localparam logic [1:0] HDR   = 2'd1;
    localparam logic [1:0] META  = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       meta_hs, data_hs;
    logic       datap_ctrl_last_data, datap_ctrl_no_data, datap_len_err;
    flit_sel_e  flit_sel;

    // outputs are forced low while reset is asserted
    assign to_udp_src_meta_rdy = ~rst & (state_q == READY);
    assign to_udp_src_data_rdy = ~rst & (state_q == DATA) & udp_to_noc_rdy;
    assign noc_to_udp_val      = ~rst & ((state_q == HDR) | (state_q == META) |
                                         ((state_q == DATA) & src_to_udp_data_val));
    assign meta_hs             = src_to_udp_meta_val & to_udp_src_meta_rdy;
    assign data_hs             = src_to_udp_data_val & to_udp_src_data_rdy;
    assign flit_sel            = rst                ? FLIT_NONE :
                                 (state_q == HDR)   ? FLIT_HDR  :
                                 (state_q == META)  ? FLIT_META :
                                 (state_q == DATA)  ? FLIT_DATA : FLIT_NONE;
    assign len_err             = ~rst & datap_len_err;

    // message sequencing: descriptor -> header -> metadata -> payload flits
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            READY:   if (meta_hs) state_d = HDR;
            HDR:     if (udp_to_noc_rdy) state_d = META;
            META:    if (udp_to_noc_rdy) state_d = datap_ctrl_no_data ? READY : DATA;
            default: if (data_hs && datap_ctrl_last_data) state_d = READY;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? READY : state_d;
    end

    to_udp_datap #(
        .NOC_DATA_W (NOC_DATA_W),
        .SRC_X      (SRC_X),
        .SRC_Y      (SRC_Y),
        .DST_X      (DST_X),
        .DST_Y      (DST_Y),
        .DST_FBITS  (DST_FBITS)
    ) u_datap (
        .clk                  (clk),
        .rst                  (rst),
        .store_info_i         (meta_hs),
        .incr_cnt_i           (data_hs),
        .flit_sel_i           (flit_sel),
        .info_i               (src_to_udp_meta_info),
        .src_data_i           (src_to_udp_data),
        .src_data_last_i      (src_to_udp_data_last),
        .noc_data_o           (noc_to_udp_data),
        .datap_ctrl_last_data (datap_ctrl_last_data),
        .datap_ctrl_no_data   (datap_ctrl_no_data),
        .len_err_o            (datap_len_err)
    );

endmodule

// File: tb/tb_to_udp_adapter.sv
// tb_to_udp_adapter: randomized self-checking bench with a flit-list reference model
module tb_to_udp_adapter;
    import to_udp_adapter_pkg::*;

    localparam logic [XY_WIDTH-1:0]        SX = 8'd3;
    localparam logic [XY_WIDTH-1:0]        SY = 8'd4;
    localparam logic [XY_WIDTH-1:0]        DX = 8'd5;
    localparam logic [XY_WIDTH-1:0]        DY = 8'd6;
    localparam logic [NOC_FBITS_WIDTH-1:0] DF = 4'h2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         src_to_udp_meta_val = 1'b0;
    udp_info      src_to_udp_meta_info = '0;
    logic         to_udp_src_meta_rdy;
    logic         src_to_udp_data_val = 1'b0;
    logic [511:0] src_to_udp_data = '0;
    logic         src_to_udp_data_last = 1'b0;
    logic         to_udp_src_data_rdy;
    logic         noc_to_udp_val;
    logic [511:0] noc_to_udp_data;
    logic         udp_to_noc_rdy = 1'b1;
    logic         len_err;

    int           tests = 0;
    int           fails = 0;
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    int           stab_viol = 0;
    bit           data_rdy_seen = 0;
    logic         held_v = 1'b0;
    logic [511:0] held_d = '0;

    always #5 clk = ~clk;

    to_udp_adapter #(
        .NOC_DATA_W (512),
        .SRC_X      (SX),
        .SRC_Y      (SY),
        .DST_X      (DX),
        .DST_Y      (DY),
        .DST_FBITS  (DF)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .src_to_udp_meta_val  (src_to_udp_meta_val),
        .src_to_udp_meta_info (src_to_udp_meta_info),
        .to_udp_src_meta_rdy  (to_udp_src_meta_rdy),
        .src_to_udp_data_val  (src_to_udp_data_val),
        .src_to_udp_data      (src_to_udp_data),
        .src_to_udp_data_last (src_to_udp_data_last),
        .to_udp_src_data_rdy  (to_udp_src_data_rdy),
        .noc_to_udp_val       (noc_to_udp_val),
        .noc_to_udp_data      (noc_to_udp_data),
        .udp_to_noc_rdy       (udp_to_noc_rdy),
        .len_err              (len_err)
    );

    // flit monitor: record accepted flits, flag flits that change while stalled
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && !(noc_to_udp_val && noc_to_udp_data == held_d)) stab_viol++;
            if (noc_to_udp_val && udp_to_noc_rdy) got_q.push_back(noc_to_udp_data);
            if (to_udp_src_data_rdy) data_rdy_seen = 1;
            held_v = noc_to_udp_val && !udp_to_noc_rdy;
            held_d = noc_to_udp_data;
        end
    end

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic udp_info rand_info(input int len);
        udp_info u;
        u.src_ip      = $urandom;
        u.dst_ip      = $urandom;
        u.src_port    = 16'($urandom_range(65535));
        u.dst_port    = 16'($urandom_range(65535));
        u.data_length = 16'(len);
        return u;
    endfunction

    function automatic int flits_for(input int len);
        return (len + 63) / 64;
    endfunction

    function automatic logic [511:0] exp_hdr(input int nfl);
        udp_noc_hdr_flit h;
        logic [511:0]    w;
        h           = '0;
        h.dst_x     = DX;
        h.dst_y     = DY;
        h.dst_fbits = DF;
        h.msg_len   = MSG_LENGTH_WIDTH'(nfl + 1);
        h.msg_type  = UDP_TX_SEGMENT;
        h.src_x     = SX;
        h.src_y     = SY;
        w           = '0;
        w[511 -: $bits(udp_noc_hdr_flit)] = h;
        return w;
    endfunction

    function automatic logic [511:0] exp_meta(input udp_info u);
        udp_tx_metadata_flit m;
        logic [511:0]        w;
        m.src_ip      = u.src_ip;
        m.dst_ip      = u.dst_ip;
        m.src_port    = u.src_port;
        m.dst_port    = u.dst_port;
        m.data_length = u.data_length;
        w             = '0;
        w[511 -: $bits(udp_tx_metadata_flit)] = m;
        return w;
    endfunction

    // Drives one descriptor plus payload; starts and ends at posedge+#1.
    // abort_after>=0 raises rst once that many payload flits were accepted.
    task automatic run_msg(input udp_info info, input int stall_pct, input bit bad_last,
                           input int abort_after, output bit done, output int ret_cycles);
        logic [511:0] words[$];
        int  nfl, widx, t_acc;
        bit  acc, meta_hs, data_hs;
        nfl = flits_for(int'(info.data_length));
        widx = 0; t_acc = 0; acc = 0; done = 0; ret_cycles = -1;
        for (int i = 0; i < nfl; i++) words.push_back(rand_word());
        exp_q = {};
        exp_q.push_back(exp_hdr(nfl));
        exp_q.push_back(exp_meta(info));
        foreach (words[i]) exp_q.push_back(words[i]);
        got_q = {};
        data_rdy_seen = 0;
        stab_viol = 0;
        src_to_udp_meta_info = info;
        src_to_udp_meta_val  = 1'b1;
        src_to_udp_data_val  = nfl > 0;
        src_to_udp_data      = nfl > 0 ? words[0] : '0;
        src_to_udp_data_last = bad_last ? 1'b1 : (nfl == 1);
        udp_to_noc_rdy       = int'($urandom_range(99)) >= stall_pct;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (acc && to_udp_src_meta_rdy && ret_cycles < 0) ret_cycles = c - t_acc;
            meta_hs = src_to_udp_meta_val && to_udp_src_meta_rdy;
            data_hs = src_to_udp_data_val && to_udp_src_data_rdy;
            if (meta_hs) begin acc = 1; t_acc = c; end
            @(posedge clk);
            #1;
            if (meta_hs) src_to_udp_meta_val = 1'b0;
            if (data_hs) begin
                widx++;
                src_to_udp_data_val  = widx < nfl;
                src_to_udp_data      = widx < nfl ? words[widx] : '0;
                src_to_udp_data_last = bad_last ? 1'b0 : (widx == nfl - 1);
            end
            if (abort_after >= 0 && got_q.size() >= 2 + abort_after) begin
                rst = 1'b1;
                src_to_udp_meta_val = 1'b0;
                src_to_udp_data_val = 1'b0;
                done = 1;
            end else if (acc && ret_cycles >= 0 && got_q.size() >= exp_q.size()) begin
                done = 1;
            end
            udp_to_noc_rdy = int'($urandom_range(99)) >= stall_pct;
        end
        src_to_udp_data_val = 1'b0;
        udp_to_noc_rdy      = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (to_udp_src_meta_rdy !== 1'b0) begin fails++; $display("FAIL reset meta_rdy got %b exp 0", to_udp_src_meta_rdy); end
        tests++; if (to_udp_src_data_rdy !== 1'b0) begin fails++; $display("FAIL reset data_rdy got %b exp 0", to_udp_src_data_rdy); end
        tests++; if (noc_to_udp_val !== 1'b0) begin fails++; $display("FAIL reset noc_val got %b exp 0", noc_to_udp_val); end
        tests++; if (noc_to_udp_data !== '0) begin fails++; $display("FAIL reset noc_data got %h exp 0", noc_to_udp_data); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL reset len_err got %b exp 0", len_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (to_udp_src_meta_rdy !== 1'b1) begin fails++; $display("FAIL idle meta_rdy got %b exp 1", to_udp_src_meta_rdy); end
        tests++; if (noc_to_udp_val !== 1'b0) begin fails++; $display("FAIL idle noc_val got %b exp 0", noc_to_udp_val); end
        @(posedge clk); #1;
    endtask

    task automatic test_lengths();
        int lens[6] = '{100, 0, 64, 65, 1, 65535};
        bit done;
        int ret, nfl;
        foreach (lens[k]) begin
            nfl = flits_for(lens[k]);
            run_msg(rand_info(lens[k]), 0, 0, -1, done, ret);
            tests++; if (!done) begin fails++; $display("FAIL len%0d timeout got done=0 exp 1", lens[k]); end
            tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL len%0d flit_count got %0d exp %0d", lens[k], got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL len%0d flit[%0d] got %h exp %h", lens[k], i, got_q[i], exp_q[i]); end
            end
            tests++; if (ret != nfl + 3) begin fails++; $display("FAIL len%0d meta_rdy_return got %0d exp %0d", lens[k], ret, nfl + 3); end
            tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL len%0d len_err got %b exp 0", lens[k], len_err); end
            if (lens[k] == 0) begin
                tests++; if (data_rdy_seen) begin fails++; $display("FAIL len0 data_rdy got 1 exp never"); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit done;
        int ret, len;
        for (int k = 0; k < 8; k++) begin
            len = int'($urandom_range(400));
            run_msg(rand_info(len), 30, 0, -1, done, ret);
            tests++; if (!done) begin fails++; $display("FAIL bp%0d timeout got done=0 exp 1", k); end
            tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp%0d flit_count got %0d exp %0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp%0d flit[%0d] got %h exp %h", k, i, got_q[i], exp_q[i]); end
            end
            tests++; if (stab_viol != 0) begin fails++; $display("FAIL bp%0d stall_stability got %0d changes exp 0", k, stab_viol); end
        end
    endtask

    task automatic test_abort();
        bit done;
        int ret;
        run_msg(rand_info(150), 0, 0, 1, done, ret);
        tests++; if (!done) begin fails++; $display("FAIL abort timeout got done=0 exp 1"); end
        @(negedge clk);
        tests++; if (to_udp_src_meta_rdy !== 1'b0) begin fails++; $display("FAIL abort meta_rdy got %b exp 0", to_udp_src_meta_rdy); end
        tests++; if (to_udp_src_data_rdy !== 1'b0) begin fails++; $display("FAIL abort data_rdy got %b exp 0", to_udp_src_data_rdy); end
        tests++; if (noc_to_udp_val !== 1'b0) begin fails++; $display("FAIL abort noc_val got %b exp 0", noc_to_udp_val); end
        tests++; if (noc_to_udp_data !== '0) begin fails++; $display("FAIL abort noc_data got %h exp 0", noc_to_udp_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_msg(rand_info(150), 0, 0, -1, done, ret);
        tests++; if (!done) begin fails++; $display("FAIL post_abort timeout got done=0 exp 1"); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL post_abort flit_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL post_abort flit[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_len_check();
        bit   done;
        int   ret;
        logic exp_err;
`ifdef TO_UDP_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_msg(rand_info(100), 0, 1, -1, done, ret);
        tests++; if (!done) begin fails++; $display("FAIL lenchk timeout got done=0 exp 1"); end
        tests++; if (got_q.size() != 4) begin fails++; $display("FAIL lenchk flit_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL lenchk flit[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        @(negedge clk);
        tests++; if (len_err !== exp_err) begin fails++; $display("FAIL lenchk len_err got %b exp %b", len_err, exp_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL lenchk_clear len_err got %b exp 0", len_err); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lengths();
        test_backpressure();
        test_abort();
        test_len_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
